// File: rtl/vram_arb_pkg.sv
// Shared requester IDs, widths and helpers for the VRAM bus arbiter.
package vram_arb_pkg;

    localparam int unsigned ADDR_W_DEF    = 15;
    localparam int unsigned REN_ADDR_W    = 16;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BE_W          = 4;
    localparam int unsigned NUM_RENDERERS = 3;
    localparam int unsigned NUM_REQ       = 4;

    typedef enum logic [1:0] {
        REQ_L0  = 2'd0,
        REQ_L1  = 2'd1,
        REQ_SPR = 2'd2,
        REQ_CPU = 2'd3
    } req_id_e;

    typedef struct packed {
        logic [DATA_W-1:0] wrdata;
        logic [BE_W-1:0]   bytesel;
    } ram_wr_t;

    // Renderer that follows id in the L0 -> L1 -> SPR ring.
    function automatic logic [1:0] rr_next(input logic [1:0] id);
        case (id)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vram_bus_arbiter_rr_select3.sv
// Combinational three-way round-robin pick starting at ptr_i, searching L0 -> L1 -> SPR with wrap.
module rr_select3
    import vram_arb_pkg::*;
(
    input  logic [NUM_RENDERERS-1:0] req_i,
    input  logic [1:0]               ptr_i,
    output logic [1:0]               winner_c_o,
    output logic                     valid_c_o
);

    logic [NUM_RENDERERS:0] req_pad;
    logic [1:0]             idx;

    assign req_pad = {1'b0, req_i};

    always_comb begin
        winner_c_o = 2'd0;
        valid_c_o  = 1'b0;
        idx        = ptr_i;
        for (int unsigned k = 0; k < NUM_RENDERERS; k++) begin
            if (!valid_c_o && req_pad[idx]) begin
                winner_c_o = idx;
                valid_c_o  = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
    end

endmodule

// File: rtl/vram_bus_arbiter.sv
// Shares the single VRAM port: CPU first, renderers round-robin when VRAM_ARB_ROUND_ROBIN_EN
// is defined, otherwise fixed L0 > L1 > SPR. One access per cycle, ack one cycle later.
module vram_bus_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REN_ADDR_W-1:0] l0_addr,
    input  logic                  l0_strobe,
    output logic                  l0_ack,
    input  logic [REN_ADDR_W-1:0] l1_addr,
    input  logic                  l1_strobe,
    output logic                  l1_ack,
    input  logic [REN_ADDR_W-1:0] spr_addr,
    input  logic                  spr_strobe,
    output logic                  spr_ack,
    output logic [DATA_W-1:0]     rd_data,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wrdata,
    input  logic [BE_W-1:0]       cpu_wrbytesel,
    input  logic                  cpu_write,
    input  logic                  cpu_strobe,
    output logic                  cpu_ack,
    output logic [DATA_W-1:0]     cpu_rddata,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wrdata,
    output logic [BE_W-1:0]       ram_wrbytesel,
    output logic                  ram_write,
    input  logic [DATA_W-1:0]     ram_rddata
);

    logic [NUM_RENDERERS-1:0] ren_req;
    logic [1:0]               ren_win;
    logic                     ren_vld;
    logic                     win_vld;
    req_id_e                  win_id;
    logic                     grant_vld_r, grant_vld_d;
    req_id_e                  grant_id_r, grant_id_d;
    logic [NUM_REQ-1:0]       ack_q, ack_d;
    logic [ADDR_W-1:0]        ram_addr_q;
    ram_wr_t                  cpu_wr;
    logic                     unused_addr_bits;

    assign ren_req = {spr_strobe, l1_strobe, l0_strobe};
    assign cpu_wr  = '{wrdata: cpu_wrdata, bytesel: cpu_wrbytesel};

    // Renderer addresses are wider than the VRAM; the top bits carry no meaning here.
    assign unused_addr_bits = ^{l0_addr[REN_ADDR_W-1:ADDR_W],
                                l1_addr[REN_ADDR_W-1:ADDR_W],
                                spr_addr[REN_ADDR_W-1:ADDR_W]};

`ifdef VRAM_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;

    rr_select3 u_rr_select3 (
        .req_i      (ren_req),
        .ptr_i      (rr_ptr_q),
        .winner_c_o (ren_win),
        .valid_c_o  (ren_vld)
    );

    // Only renderer grants move the pointer; CPU grants leave it where it was.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_vld && (win_id != REQ_CPU)) begin
            rr_ptr_d = rr_next(ren_win);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 2'(REQ_L0);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        ren_vld = |ren_req;
        ren_win = 2'(REQ_L0);
        if (l0_strobe) begin
            ren_win = 2'(REQ_L0);
        end else if (l1_strobe) begin
            ren_win = 2'(REQ_L1);
        end else if (spr_strobe) begin
            ren_win = 2'(REQ_SPR);
        end
    end
`endif

    // Winner is suppressed while rst is held so the RAM port shows its reset values.
    always_comb begin
        win_vld = 1'b0;
        win_id  = REQ_CPU;
        if (!rst) begin
            if (cpu_strobe) begin
                win_vld = 1'b1;
                win_id  = REQ_CPU;
            end else if (ren_vld) begin
                win_vld = 1'b1;
                win_id  = req_id_e'(ren_win);
            end
        end
    end

    always_comb begin
        ram_addr      = ram_addr_q;
        ram_write     = 1'b0;
        ram_wrdata    = cpu_wr.wrdata;
        ram_wrbytesel = cpu_wr.bytesel;
        if (win_vld) begin
            case (win_id)
                REQ_L0:  ram_addr = l0_addr[ADDR_W-1:0];
                REQ_L1:  ram_addr = l1_addr[ADDR_W-1:0];
                REQ_SPR: ram_addr = spr_addr[ADDR_W-1:0];
                default: begin
                    ram_addr  = cpu_addr;
                    ram_write = cpu_write;
                end
            endcase
        end
    end

    always_comb begin
        grant_vld_d = win_vld;
        grant_id_d  = win_id;
        ack_d       = '0;
        if (win_vld) begin
            ack_d[win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_vld_r <= 1'b0;
            grant_id_r  <= REQ_L0;
            ack_q       <= '0;
            ram_addr_q  <= '0;
        end else begin
            grant_vld_r <= grant_vld_d;
            grant_id_r  <= grant_id_d;
            ack_q       <= ack_d;
            ram_addr_q  <= ram_addr;
        end
    end

    assign l0_ack  = ack_q[REQ_L0];
    assign l1_ack  = ack_q[REQ_L1];
    assign spr_ack = ack_q[REQ_SPR];
    assign cpu_ack = ack_q[REQ_CPU];

    // BRAM data is gated by the grant so nothing undriven leaks out between accesses.
    assign rd_data    = (grant_vld_r && (grant_id_r != REQ_CPU)) ? ram_rddata : '0;
    assign cpu_rddata = (grant_vld_r && (grant_id_r == REQ_CPU)) ? ram_rddata : '0;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Scoreboard bench for vram_bus_arbiter: stimulus queues expected acks, a monitor thread checks them.
module tb_vram_bus_arbiter;
    import vram_arb_pkg::*;

    localparam int unsigned AW = ADDR_W_DEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [REN_ADDR_W-1:0] l0_addr, l1_addr, spr_addr;
    logic                  l0_hold, l1_hold, spr_hold, cpu_hold, keep;
    logic                  l0_strobe, l1_strobe, spr_strobe, cpu_strobe;
    logic                  l0_ack, l1_ack, spr_ack, cpu_ack;
    logic [31:0]           rd_data, cpu_rddata, cpu_wrdata, ram_wrdata, ram_rddata;
    logic [AW-1:0]         cpu_addr, ram_addr;
    logic [3:0]            cpu_wrbytesel, ram_wrbytesel;
    logic                  cpu_write, ram_write;
    logic [3:0]            acks;

    // Masters drop strobe in their ack cycle; keep models a master re-requesting every cycle.
    assign l0_strobe  = l0_hold  & ~(l0_ack  & ~keep);
    assign l1_strobe  = l1_hold  & ~(l1_ack  & ~keep);
    assign spr_strobe = spr_hold & ~(spr_ack & ~keep);
    assign cpu_strobe = cpu_hold & ~(cpu_ack & ~keep);
    assign acks       = {cpu_ack, spr_ack, l1_ack, l0_ack};

    vram_bus_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .l0_addr       (l0_addr),
        .l0_strobe     (l0_strobe),
        .l0_ack        (l0_ack),
        .l1_addr       (l1_addr),
        .l1_strobe     (l1_strobe),
        .l1_ack        (l1_ack),
        .spr_addr      (spr_addr),
        .spr_strobe    (spr_strobe),
        .spr_ack       (spr_ack),
        .rd_data       (rd_data),
        .cpu_addr      (cpu_addr),
        .cpu_wrdata    (cpu_wrdata),
        .cpu_wrbytesel (cpu_wrbytesel),
        .cpu_write     (cpu_write),
        .cpu_strobe    (cpu_strobe),
        .cpu_ack       (cpu_ack),
        .cpu_rddata    (cpu_rddata),
        .ram_addr      (ram_addr),
        .ram_wrdata    (ram_wrdata),
        .ram_wrbytesel (ram_wrbytesel),
        .ram_write     (ram_write),
        .ram_rddata    (ram_rddata)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM: word a holds 0x1234_0000 + a, except 0x123 = 0xDEADBEEF; writes overlay it.
    logic [31:0] wmem [int];

    function automatic logic [31:0] base_word(input logic [AW-1:0] a);
        return (a == 15'h123) ? 32'hDEAD_BEEF : (32'h1234_0000 + 32'(a));
    endfunction

    always @(posedge clk) begin : bram
        logic [31:0] cur;
        cur = wmem.exists(int'(ram_addr)) ? wmem[int'(ram_addr)] : base_word(ram_addr);
        ram_rddata <= cur;
        if (ram_write) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wrbytesel[b]) cur[8*b +: 8] = ram_wrdata[8*b +: 8];
            end
            wmem[int'(ram_addr)] = cur;
        end
    end

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        logic        chk;
        int unsigned cyc;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [31:0] data, input logic chk,
                            input int unsigned c);
        exp_t e;
        e.id = id; e.data = data; e.chk = chk; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic monitor();
        exp_t        e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            for (int r = 0; r < 4; r++) begin
                if (acks[r]) begin
                    tests++;
                    got = (r == 3) ? cpu_rddata : rd_data;
                    if (sbq.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_ack: got id=%0d at cyc=%0d, expected no ack", r, cyc);
                    end else begin
                        e = sbq.pop_front();
                        if ((32'(e.id) != 32'(r)) || (e.cyc != cyc) || (e.chk && (got !== e.data))) begin
                            fails++;
                            $display("FAIL ack_seq: got id=%0d cyc=%0d data=%h, expected id=%0d cyc=%0d data=%h",
                                     r, cyc, got, e.id, e.cyc, e.data);
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!keep) begin
            if (l0_ack)  l0_hold  = 1'b0;
            if (l1_ack)  l1_hold  = 1'b0;
            if (spr_ack) spr_hold = 1'b0;
            if (cpu_ack) cpu_hold = 1'b0;
        end
    endtask

    initial begin
        int unsigned c0;
        logic [1:0]  id;

        rst = 1'b1;
        l0_hold = 1'b0; l1_hold = 1'b0; spr_hold = 1'b0; cpu_hold = 1'b0; keep = 1'b0;
        l0_addr = '0; l1_addr = '0; spr_addr = '0;
        cpu_addr = '0; cpu_wrdata = '0; cpu_wrbytesel = '0; cpu_write = 1'b0;
        fork
            monitor();
        join_none

        tick(); tick();
        check("reset_acks", 32'(acks), 32'h0);
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_cpu_rddata", cpu_rddata, 32'h0);
        check("reset_ram_write", 32'(ram_write), 32'h0);
        check("reset_ram_addr", 32'(ram_addr), 32'h0);
        rst = 1'b0;
        tick();

        // Renderer contention with continuous re-requests.
        l0_addr = 16'h0040; l1_addr = 16'h0041; spr_addr = 16'h0042;
        keep = 1'b1; l0_hold = 1'b1; l1_hold = 1'b1; spr_hold = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 6; k++) begin
`ifdef VRAM_ARB_ROUND_ROBIN_EN
            id = 2'(k % 3);
`else
            id = 2'd0;
`endif
            push_exp(id, 32'h1234_0040 + 32'(id), 1'b1, c0 + 32'(k) + 1);
        end
        repeat (6) tick();
        l0_hold = 1'b0; l1_hold = 1'b0; spr_hold = 1'b0; keep = 1'b0;
        tick();

        // Single L0 read.
        l0_addr = 16'h0123; l0_hold = 1'b1;
        push_exp(2'(REQ_L0), 32'hDEAD_BEEF, 1'b1, cyc + 1);
        #1 check("single_ram_addr", 32'(ram_addr), 32'h123);
        check("single_ram_write", 32'(ram_write), 32'h0);
        tick(); tick();

        // CPU write preempts a sprite request.
        spr_addr = 16'h0077; spr_hold = 1'b1;
        cpu_addr = 15'h10; cpu_wrdata = 32'hA5A5_A5A5; cpu_wrbytesel = 4'b0011;
        cpu_write = 1'b1; cpu_hold = 1'b1;
        push_exp(2'(REQ_CPU), 32'h0, 1'b0, cyc + 1);
        push_exp(2'(REQ_SPR), 32'h1234_0077, 1'b1, cyc + 2);
        #1 check("cpu_wr_ram_write", 32'(ram_write), 32'h1);
        check("cpu_wr_ram_addr", 32'(ram_addr), 32'h10);
        check("cpu_wr_bytesel", 32'(ram_wrbytesel), 32'h3);
        check("cpu_wr_data", ram_wrdata, 32'hA5A5_A5A5);
        tick();
        #1 check("spr_after_cpu_addr", 32'(ram_addr), 32'h77);
        check("spr_after_cpu_write", 32'(ram_write), 32'h0);
        tick(); tick();
        cpu_write = 1'b0; cpu_hold = 1'b1;
        push_exp(2'(REQ_CPU), 32'h1234_A5A5, 1'b1, cyc + 1);
        tick(); tick();

        // Back-to-back reads; bit 15 of the sprite address must be ignored.
        l1_addr = 16'h0200; spr_addr = 16'h8301; l1_hold = 1'b1; spr_hold = 1'b1;
        push_exp(2'(REQ_L1), 32'h1234_0200, 1'b1, cyc + 1);
        push_exp(2'(REQ_SPR), 32'h1234_0301, 1'b1, cyc + 2);
        tick();
        #1 check("b2b_spr_ram_addr", 32'(ram_addr), 32'h301);
        tick(); tick();

        // Move the pointer past L0, then abort a sprite request while the CPU owns the bus.
        l0_addr = 16'h0005; l0_hold = 1'b1;
        push_exp(2'(REQ_L0), 32'h1234_0005, 1'b1, cyc + 1);
        tick(); tick();
        cpu_addr = 15'h20; cpu_write = 1'b0; keep = 1'b1; cpu_hold = 1'b1;
        spr_addr = 16'h0009; spr_hold = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 3; k++) push_exp(2'(REQ_CPU), 32'h1234_0020, 1'b1, c0 + 32'(k));
        tick(); tick();
        spr_hold = 1'b0;
        tick();
        cpu_hold = 1'b0; keep = 1'b0;
        tick();
        l0_addr = 16'h0100; l1_addr = 16'h0101; spr_addr = 16'h0102;
        l0_hold = 1'b1; l1_hold = 1'b1; spr_hold = 1'b1;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
        push_exp(2'(REQ_L1), 32'h1234_0101, 1'b1, cyc + 1);
        push_exp(2'(REQ_SPR), 32'h1234_0102, 1'b1, cyc + 2);
        push_exp(2'(REQ_L0), 32'h1234_0100, 1'b1, cyc + 3);
`else
        push_exp(2'(REQ_L0), 32'h1234_0100, 1'b1, cyc + 1);
        push_exp(2'(REQ_L1), 32'h1234_0101, 1'b1, cyc + 2);
        push_exp(2'(REQ_SPR), 32'h1234_0102, 1'b1, cyc + 3);
`endif
        repeat (4) tick();

        // Reset lands between the L0 grant and its ack.
        l0_addr = 16'h0033; l0_hold = 1'b1;
        #1 check("rst_mid_grant_addr", 32'(ram_addr), 32'h33);
        #1 rst = 1'b1; l0_hold = 1'b0;
        #1 check("rst_mid_ram_addr_async", 32'(ram_addr), 32'h0);
        tick();
        check("rst_mid_acks", 32'(acks), 32'h0);
        check("rst_mid_rd_data", rd_data, 32'h0);
        check("rst_mid_cpu_rddata", cpu_rddata, 32'h0);
        check("rst_mid_ram_write", 32'(ram_write), 32'h0);
        check("rst_mid_ram_addr", 32'(ram_addr), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        l0_addr = 16'h0050; l1_addr = 16'h0051; spr_addr = 16'h0052;
        l0_hold = 1'b1; l1_hold = 1'b1; spr_hold = 1'b1;
        push_exp(2'(REQ_L0), 32'h1234_0050, 1'b1, cyc + 1);
        push_exp(2'(REQ_L1), 32'h1234_0051, 1'b1, cyc + 2);
        push_exp(2'(REQ_SPR), 32'h1234_0052, 1'b1, cyc + 3);
        repeat (6) tick();

        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vram_bus_arbiter.md
# vram_bus_arbiter

Shares the single-ported 32-bit VRAM read/write port between four requesters: the layer 0 renderer, the layer 1 renderer, the sprite renderer, and the CPU register interface. It sits between those bus masters and the VRAM block RAM. It grants at most one access per cycle and returns read data with a one-cycle ack. The bus-master handshake is the one the renderers already use: hold strobe until ack, and drop strobe combinationally in the ack cycle.

## Interface
- ADDR_W, 15: VRAM word-address width (32-bit words, 128 KB).
- Ports below, one per line.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- l0_addr  in  16  layer 0 word address; bits above ADDR_W are ignored.
- l0_strobe  in  1  layer 0 read request.
- l0_ack  out  1  layer 0 read-data-valid pulse.
- l1_addr / l1_strobe / l1_ack: same as l0, for layer 1.
- spr_addr / spr_strobe / spr_ack: same as l0, for the sprite renderer.
- rd_data  out  32  read data broadcast to all renderers; valid only in a requester's ack cycle.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wrdata  in  32  CPU write data.
- cpu_wrbytesel  in  4  CPU byte enables; bit i enables byte i.
- cpu_write  in  1  1 = write, 0 = read; qualified by cpu_strobe.
- cpu_strobe  in  1  CPU request.
- cpu_ack  out  1  CPU completion pulse.
- cpu_rddata  out  32  CPU read data; valid in the cpu_ack cycle.
- ram_addr  out  ADDR_W  BRAM address; the BRAM registers it internally.
- ram_wrdata  out  32  BRAM write data.
- ram_wrbytesel  out  4  BRAM byte enables.
- ram_write  out  1  BRAM write enable.
- ram_rddata  in  32  BRAM read data; valid one cycle after the address cycle.

## Operation
- Requester IDs: L0=0, L1=1, SPR=2, CPU=3.
- Arbitration is combinational over the current strobes in each cycle.
- The CPU has absolute priority.
- Among the renderers, the pick order is round-robin (see Configuration).
- The winner's address is driven onto ram_addr in the same cycle.
- ram_write is asserted only when the winner is the CPU with cpu_write=1.
- When there is no winner:
  - ram_write=0;
  - ram_addr holds its last value.
- Winner ID and valid are registered as grant_id_r and grant_vld_r.
- The next cycle pulses the matching ack for exactly one cycle.
- rd_data and cpu_rddata follow ram_rddata combinationally in the ack cycle. Outside the ack cycle they are don't-care, but they must not produce X in simulation.
- A CPU write acks in the same slot as a read would; read data returned for a write is undefined.
- A requester in its ack cycle has already deasserted its strobe, so it is never re-granted in that cycle. Back-to-back grants to different requesters give one access per cycle.
- There is no queueing: a losing strobe simply stays high until granted.

## Timing
- Minimum latency from strobe to ack is 1 cycle (grant in cycle N, ack in N+1).
- Fixed-priority worst-case renderer wait: unbounded while the CPU strobes continuously. Round-robin worst-case renderer wait is 2 renderer grants plus CPU grants.
- Reset values:
  - all acks 0;
  - grant_vld_r=0;
  - rd_data and cpu_rddata 0 (pass-through is gated by grant_vld_r);
  - ram_write=0;
  - ram_addr=0;
  - round-robin pointer = L0.
- Reset mid-access: the pending ack is discarded. A requester must re-strobe after reset; renderers are reset together with the arbiter.
- Simultaneous strobes from all four requesters: CPU first, then renderers in round-robin order, one per cycle.
- A strobe dropped before it is granted (e.g. line_render_start aborting a renderer) leaves no side effects.

## Configuration
- VRAM_ARB_ROUND_ROBIN_EN defined:
  - renderer pick starts at the round-robin pointer and searches L0→L1→SPR with wrap;
  - after a renderer grant, the pointer moves to (winner+1) mod 3;
  - CPU grants leave the pointer unchanged.
- VRAM_ARB_ROUND_ROBIN_EN not defined:
  - fixed priority CPU > L0 > L1 > SPR;
  - the pointer register is not implemented.

## Structure
- Package vram_arb_pkg holds:
  - the requester ID enum (2 bits) with REQ_L0, REQ_L1, REQ_SPR, REQ_CPU;
  - ADDR_W default;
  - NUM_RENDERERS=3.
- Sub-module rr_select3 (used only under the macro) is purely combinational. Inputs: 3-bit request vector and 2-bit pointer. Outputs: 2-bit winner and a valid flag.
- Grant/ack register pipeline and muxes live in the top module.

## Test plan
- Single request: l0_strobe with l0_addr=0x0123 and ram_rddata[0x123]=0xDEADBEEF → ram_addr=0x123 in cycle N; l0_ack=1 with rd_data=0xDEADBEEF in N+1; no other ack fires.
- Renderer contention: all three renderer strobes held for 6 grants, round-robin build → ack order L0,L1,SPR,L0,L1,SPR; fixed-priority build → L0 acked every cycle and L1/SPR starved.
- CPU preemption: CPU write addr 0x10, data 0xA5A5A5A5, bytesel 4'b0011, issued together with spr_strobe → cpu_ack in N+1; spr_ack in N+2; a subsequent read of 0x10 returns only bytes 0–1 changed.
- Back-to-back reads: L1 and SPR strobe, and each drops on its own ack → one ack per cycle, no cycle without an ack, and each rd_data matches its address.
- Reset mid-access: assert rst in the cycle after granting L0 → l0_ack stays 0; all outputs read their reset values; after release, the first grant follows pointer=L0.
- Aborted request: spr_strobe dropped before grant while the CPU holds the bus → spr_ack is never asserted, and the pointer is unchanged.
